asynchronous_fifo: RTL and testbench
====================================

Name: asynchronous_fifo

Overview:
- Single-clock, synchronous first-in-first-out buffer for WIDTH-bit words, DEPTH entries deep.
- Decouples a producer from a consumer that share one clock domain. Provides full/empty status flags.
- Writes to a full FIFO and reads from an empty FIFO are ignored.

Parameters:
- DEPTH, 8, number of storage entries; power of two, at least 2.
- WIDTH, 8, data word width in bits.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset.
- w_en  in  1  write request; data_in is stored if not full.
- rd_en  in  1  read request; the head word is popped to data_out if not empty.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  registered read data.
- full  out  1  high when DEPTH words are stored.
- empty  out  1  high when 0 words are stored.
- Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Storage: DEPTH x WIDTH register array. The array is not reset.
- Pointers: wr_ptr and rd_ptr, each AW+1 bits, where AW = log2(DEPTH). The low AW bits address the array. The MSB is a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs of the pointers differ) and (low AW bits are equal).
- Both flags are decoded combinationally from the registered pointers. They never assert together.
- Write accept: w_en && !full, sampled at the rising edge.
  - Action: mem[wr_ptr[AW-1:0]] <= data_in; wr_ptr increments, wrapping modulo 2^(AW+1).
- Read accept: rd_en && !empty, sampled at the rising edge.
  - Action: data_out <= mem[rd_ptr[AW-1:0]]; rd_ptr increments.
  - data_out is valid immediately after that edge (1-cycle latency from rd_en).
- data_out holds its last value when no read is accepted.
- Rejected write (full): no state change. data_in is discarded and the write is not queued.
- Rejected read (empty): no state change. data_out is unchanged.
- Simultaneous w_en and rd_en:
  - Accept tests use pre-edge flags.
  - When full: only the read occurs, and full deasserts next cycle.
  - When empty: only the write occurs, and empty deasserts next cycle.
  - Otherwise: both occur, occupancy is unchanged, and the flags are unchanged.
- Flag timing: empty deasserts in the cycle after the first accepted write. full asserts after the DEPTH-th net accepted write.
- Reset (rst high at a rising edge): wr_ptr = 0, rd_ptr = 0, data_out = 0, empty = 1, full = 0.
  - Reset overrides w_en/rd_en in the same cycle.
  - Reset mid-operation discards all stored contents.
- Wrap-around: FIFO order is preserved across any number of pointer wraps.

Decomposition:
- Shared package: a clog2-based AW helper and the reset values of the pointers and data_out.
- One natural sub-module: fifo_ptr_ctrl. It holds one pointer register, with increment-on-accept and wrap logic, and is instantiated twice (write and read).
- Flag compare logic and the array live in the top level.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> empty=1, full=0, data_out=0. Asserting w_en during reset stores nothing.
- Fill: write A1,B2,C3,D4,E5,F6,07,18 on 8 consecutive cycles.
  - After the first write, empty=0.
  - After the 8th, full=1.
  - Then w_en with 99 -> full stays 1 and the contents are unchanged.
- Drain: 8 consecutive reads -> data_out = A1,B2,C3,D4,E5,F6,07,18, each one cycle after its rd_en. After the 8th read, empty=1. A 9th read leaves data_out=18.
- Simultaneous at boundaries:
  - Full plus w_en+rd_en -> one read only; full=0 next cycle.
  - Empty plus w_en+rd_en with 55 -> write only; a later read returns 55.
- Wrap/streaming: 20 cycles of concurrent write/read of an incrementing pattern, starting from 3 stored words -> output is in exact order, with no flag toggling.
- Mid-operation reset: store 5 words, assert rst -> empty=1, and a subsequent write/read of 3C returns 3C.

Source files
------------

// File: rtl/asynchronous_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: address-width helper and
// the reset values used for the pointers and the read data register.
package asynchronous_fifo_pkg;

   localparam int unsigned DEF_DEPTH = 32'd8;
   localparam int unsigned DEF_WIDTH = 32'd8;

   localparam logic PTR_RST_BIT  = 1'b0;
   localparam logic DOUT_RST_BIT = 1'b0;

   function automatic int unsigned calc_aw(input int unsigned depth);
      return (depth < 32'd2) ? 32'd1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/asynchronous_fifo_ptr_ctrl.sv
// One FIFO pointer: AW address bits plus a wrap bit, advancing by one per
// accepted transfer and wrapping naturally modulo 2^(AW+1).
module fifo_ptr_ctrl
   import asynchronous_fifo_pkg::*;
#(
   parameter int unsigned AW = 32'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_accept,
   output logic [AW:0] o_ptr
);

   logic [AW:0] r_ptr;

   // pointer register with increment-on-accept
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= {(AW + 1){PTR_RST_BIT}};
      end else if (i_accept) begin
         r_ptr <= r_ptr + {{AW{1'b0}}, 1'b1};
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO of DEPTH words by WIDTH bits with registered read data
// and full/empty flags decoded from the write and read pointers.
module asynchronous_fifo
   import asynchronous_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = calc_aw(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_data_out;
   logic [AW:0]      w_wr_ptr;
   logic [AW:0]      w_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_accept;
   logic             w_rd_accept;

   // Same address with opposite wrap bits means the writer is a full lap ahead.
   assign w_empty = (w_wr_ptr == w_rd_ptr);
   assign w_full  = (w_wr_ptr[AW] != w_rd_ptr[AW]) &&
                    (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]);

   assign w_wr_accept = w_en  && !w_full  && !rst;
   assign w_rd_accept = rd_en && !w_empty && !rst;

   fifo_ptr_ctrl #(.AW(AW)) u_wr_ptr (
      .clk      (clk),
      .rst      (rst),
      .i_accept (w_wr_accept),
      .o_ptr    (w_wr_ptr)
   );

   fifo_ptr_ctrl #(.AW(AW)) u_rd_ptr (
      .clk      (clk),
      .rst      (rst),
      .i_accept (w_rd_accept),
      .o_ptr    (w_rd_ptr)
   );

   // storage array, deliberately left without reset
   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_mem[w_wr_ptr[AW-1:0]] <= data_in;
      end
   end

   // registered read data, held when no read is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out <= {WIDTH{DOUT_RST_BIT}};
      end else if (w_rd_accept) begin
         r_data_out <= r_mem[w_rd_ptr[AW-1:0]];
      end else begin
         r_data_out <= r_data_out;
      end
   end

   assign data_out = r_data_out;
   assign full     = w_full;
   assign empty    = w_empty;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Directed, scoreboard-based bench for asynchronous_fifo (DEPTH=8, WIDTH=8).
module tb_asynchronous_fifo;

   localparam int DEPTH = 8;

   logic       clk;
   logic       rst;
   logic       w_en;
   logic       rd_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int         checks;
   int         failures;
   logic [7:0] sb_q[$];
   logic [7:0] last_dout;

   asynchronous_fifo #(.DEPTH(8), .WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .w_en     (w_en),
      .rd_en    (rd_en),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle of stimulus; the model decides acceptance from pre-edge occupancy.
   task automatic cycle(input logic we, input logic re, input logic [7:0] din);
      logic       wacc;
      logic       racc;
      logic [7:0] exp_d;
      wacc    = we && (sb_q.size() < DEPTH);
      racc    = re && (sb_q.size() > 0);
      w_en    = we;
      rd_en   = re;
      data_in = din;
      @(posedge clk);
      #1;
      if (racc) begin
         exp_d     = sb_q.pop_front();
         last_dout = exp_d;
      end
      if (wacc) sb_q.push_back(din);
      check(racc ? "read_data" : "hold_data", 32'(data_out), 32'(last_dout));
      check("empty", 32'(empty), 32'(sb_q.size() == 0));
      check("full", 32'(full), 32'(sb_q.size() == DEPTH));
      w_en  = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset(input int n, input logic we);
      rst     = 1'b1;
      w_en    = we;
      data_in = 8'h77;
      repeat (n) @(posedge clk);
      #1;
      rst  = 1'b0;
      w_en = 1'b0;
      sb_q.delete();
      last_dout = 8'h00;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_dout", 32'(data_out), 32'd0);
   endtask

   initial begin
      logic [7:0] fill_vals [8];
      logic [7:0] pat;
      fill_vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
      checks    = 0;
      failures  = 0;
      last_dout = 8'h00;
      rst       = 1'b1;
      w_en      = 1'b0;
      rd_en     = 1'b0;
      data_in   = 8'h00;

      // reset with w_en held high: nothing may be stored
      do_reset(2, 1'b1);
      cycle(1'b0, 1'b1, 8'h00);

      // fill, then a rejected write of 99
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, fill_vals[i]);
      cycle(1'b1, 1'b0, 8'h99);

      // drain, plus one read from empty
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h00);
      check("dout_after_empty_read", 32'(data_out), 32'h18);

      // simultaneous access while full: read only
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h20 + 8'(i));
      cycle(1'b1, 1'b1, 8'hEE);
      check("full_drop", 32'(full), 32'd0);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00);

      // simultaneous access while empty: write only
      cycle(1'b1, 1'b1, 8'h55);
      check("empty_drop", 32'(empty), 32'd0);
      cycle(1'b0, 1'b1, 8'h00);
      check("read_55", 32'(data_out), 32'h55);

      // streaming across pointer wraps from 3 stored words
      pat = 8'h40;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, pat);
         pat = pat + 8'h01;
      end
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, pat);
         pat = pat + 8'h01;
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);

      // mid-operation reset discards contents
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h60 + 8'(i));
      do_reset(1, 1'b0);
      cycle(1'b1, 1'b0, 8'h3C);
      cycle(1'b0, 1'b1, 8'h00);
      check("read_3c", 32'(data_out), 32'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
